// File: rtl/wavetable_fetch.sv
// wavetable_fetch
// Read-side client of the wavetable RAM. It accepts single-entry read
// requests or a full-table sweep command, drives the RAM read port, captures
// the entry one cycle later and presents it on a valid/ready response
// channel. Consumers never see RAM latency, and backpressure stalls all reads.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   req_valid/ready   single-read request handshake, req_addr = entry index
//   sweep_start       pulse: read entries 0..RAM_SIZE-1 in order
//   sweep_busy        sweep in progress
//   sweep_done        one-cycle pulse after the last sweep response is taken
//   ram_re, ram_addr  RAM read port; data is returned on ram_* one cycle later
//   ram_wfm_left/right, ram_factor, ram_is_pure   RAM read data
//   rsp_valid/ready   response handshake
//   rsp_addr, rsp_wfm_left/right, rsp_factor, rsp_is_pure   captured entry
//   rsp_err           address was out of range (data fields are zero)
//   rsp_last          final response of a sweep
module wavetable_fetch #(
    parameter int RAM_SIZE = 61,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              sweep_start,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_wfm_left,
    input  logic [DATA_W-1:0] ram_wfm_right,
    input  logic [DATA_W-1:0] ram_factor,
    input  logic              ram_is_pure,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_wfm_left,
    output logic [DATA_W-1:0] rsp_wfm_right,
    output logic [DATA_W-1:0] rsp_factor,
    output logic              rsp_is_pure,
    output logic              rsp_err,
    output logic              rsp_last
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_SIZE - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_err;
    logic              cur_sweep;
    logic              issue;
    logic              in_range;
    logic              sweep_accept;
    logic [ADDR_W-1:0] issue_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        sweep_accept = 1'b0;
        issue        = 1'b0;
        issue_addr   = cnt;
        ram_re       = 1'b0;
        ram_addr     = '0;
        rsp_valid    = 1'b0;
        in_range     = int'(issue_addr) < RAM_SIZE;
        case (state)
            IDLE: begin
                // A sweep_start in this cycle takes precedence; the pending
                // request waits until the sweep has completed.
                req_ready    = !sweep_busy && !sweep_start;
                sweep_accept = !sweep_busy && sweep_start;
                issue_addr   = sweep_busy ? cnt : req_addr;
                in_range     = int'(issue_addr) < RAM_SIZE;
                issue        = sweep_busy || (req_valid && req_ready);
                if (issue) begin
                    state_next = WAIT;
                    if (in_range) begin
                        ram_re   = 1'b1;
                        ram_addr = issue_addr;
                    end
                end
            end
            WAIT: state_next = HOLD;
            HOLD: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            cur_addr      <= '0;
            cur_err       <= 1'b0;
            cur_sweep     <= 1'b0;
            sweep_busy    <= 1'b0;
            sweep_done    <= 1'b0;
            rsp_addr      <= '0;
            rsp_wfm_left  <= '0;
            rsp_wfm_right <= '0;
            rsp_factor    <= '0;
            rsp_is_pure   <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_last      <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (sweep_accept) begin
                sweep_busy <= 1'b1;
                cnt        <= '0;
            end
            if (issue) begin
                cur_addr  <= issue_addr;
                cur_err   <= !in_range;
                cur_sweep <= sweep_busy;
                // Counter saturates at the final entry; it never wraps.
                if (sweep_busy && cnt != LAST_ADDR) cnt <= cnt + 1'b1;
            end
            // RAM data is valid only in the cycle after the read; capture it
            // here so the RAM need not hold its outputs.
            if (state == WAIT) begin
                rsp_addr <= cur_addr;
                rsp_err  <= cur_err;
                rsp_last <= cur_sweep && (cur_addr == LAST_ADDR);
                if (cur_err) begin
                    rsp_wfm_left  <= '0;
                    rsp_wfm_right <= '0;
                    rsp_factor    <= '0;
                    rsp_is_pure   <= 1'b0;
                end else begin
                    rsp_wfm_left  <= ram_wfm_left;
                    rsp_wfm_right <= ram_wfm_right;
                    rsp_factor    <= ram_factor;
                    rsp_is_pure   <= ram_is_pure;
                end
            end
            if (state == HOLD && rsp_ready && rsp_last) begin
                sweep_busy <= 1'b0;
                sweep_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wavetable_fetch.sv
// tb_wavetable_fetch
// Directed and randomized checks of wavetable_fetch against a table-based
// model: a behavioural RAM returns mem[] one cycle after a read (random junk
// otherwise), and expected responses come straight from mem[] and the
// address-range rule.
module tb_wavetable_fetch;

    localparam int RAM_SIZE = 61;
    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 8;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              sweep_start;
    logic              sweep_busy;
    logic              sweep_done;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wfm_left;
    logic [DATA_W-1:0] ram_wfm_right;
    logic [DATA_W-1:0] ram_factor;
    logic              ram_is_pure;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_wfm_left;
    logic [DATA_W-1:0] rsp_wfm_right;
    logic [DATA_W-1:0] rsp_factor;
    logic              rsp_is_pure;
    logic              rsp_err;
    logic              rsp_last;

    int checks = 0;
    int errors = 0;

    // Table entries packed as {left, right, factor, is_pure}.
    logic [24:0] mem [64];
    logic [25:0] obs;

    assign obs = {rsp_wfm_left, rsp_wfm_right, rsp_factor, rsp_is_pure, rsp_err};

    wavetable_fetch #(
        .RAM_SIZE(RAM_SIZE),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .sweep_start  (sweep_start),
        .sweep_busy   (sweep_busy),
        .sweep_done   (sweep_done),
        .ram_re       (ram_re),
        .ram_addr     (ram_addr),
        .ram_wfm_left (ram_wfm_left),
        .ram_wfm_right(ram_wfm_right),
        .ram_factor   (ram_factor),
        .ram_is_pure  (ram_is_pure),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_addr     (rsp_addr),
        .rsp_wfm_left (rsp_wfm_left),
        .rsp_wfm_right(rsp_wfm_right),
        .rsp_factor   (rsp_factor),
        .rsp_is_pure  (rsp_is_pure),
        .rsp_err      (rsp_err),
        .rsp_last     (rsp_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM: data valid only in the cycle after a read.
    always @(posedge clk) begin
        if (ram_re)
            {ram_wfm_left, ram_wfm_right, ram_factor, ram_is_pure} <= mem[ram_addr];
        else
            {ram_wfm_left, ram_wfm_right, ram_factor, ram_is_pure} <= 25'($urandom);
    end

    function automatic logic [25:0] expect_rsp(input int a);
        if (a < RAM_SIZE) return {mem[a], 1'b0};
        return 26'h1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One single read: issue, wait, hold for `stall` cycles, then handshake.
    task automatic do_read(input int a, input int stall);
        logic [25:0] exp_v;
        exp_v     = expect_rsp(a);
        req_valid = 1'b1;
        req_addr  = ADDR_W'(a);
        rsp_ready = 1'b0;
        #1;
        chk("issue_req_ready", req_ready, 1);
        chk("issue_ram_re", ram_re, a < RAM_SIZE);
        chk("issue_ram_addr", ram_addr, (a < RAM_SIZE) ? a : 0);
        tick;
        req_valid = 1'b0;
        req_addr  = ADDR_W'($urandom);
        #1;
        chk("wait_rsp_valid", rsp_valid, 0);
        chk("wait_ram_re", ram_re, 0);
        chk("wait_req_ready", req_ready, 0);
        tick;
        for (int i = 0; i < stall; i++) begin
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            req_addr  = ADDR_W'($urandom);
            #1;
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_data", obs, exp_v);
            chk("stall_addr", rsp_addr, a);
            chk("stall_last", rsp_last, 0);
            chk("stall_req_ready", req_ready, 0);
            chk("stall_ram_re", ram_re, 0);
            tick;
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", obs, exp_v);
        chk("rsp_addr", rsp_addr, a);
        chk("rsp_last", rsp_last, 0);
        tick;
        rsp_ready = 1'b0;
        #1;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_req_ready", req_ready, 1);
    endtask

    initial begin
        int k;
        int cyc;
        bit done_seen;

        rst         = 1'b1;
        req_valid   = 1'b0;
        req_addr    = '0;
        sweep_start = 1'b0;
        rsp_ready   = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 25'($urandom);

        tick;
        tick;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_sweep_busy", sweep_busy, 0);
        chk("rst_sweep_done", sweep_done, 0);
        chk("rst_ram_re", ram_re, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_rsp_fields", {rsp_addr, obs, rsp_last}, 0);
        rst = 1'b0;
        tick;

        // Directed single reads, including backpressure and out-of-range.
        mem[3] = {8'hBE, 8'hAD, 8'hDE, 1'b0};
        do_read(3, 0);
        do_read(3, 5);
        do_read(61, 0);
        do_read(63, 1);
        do_read(RAM_SIZE - 1, 0);

        // Randomized single reads over the full address space.
        repeat (25) do_read(int'($urandom_range(0, 63)), int'($urandom_range(0, 3)));

        // Full sweep with a competing request and random backpressure.
        for (int i = 0; i < RAM_SIZE; i++)
            mem[i] = (i % 2 == 0) ? {8'hBE, 8'hAD, 8'hDE, 1'b0} : {8'hAF, 8'hDC, 8'hAD, 1'b1};
        sweep_start = 1'b1;
        req_valid   = 1'b1;
        req_addr    = 6'd5;
        rsp_ready   = 1'b0;
        #1;
        chk("sweep_req_ready", req_ready, 0);
        chk("sweep_start_ram_re", ram_re, 0);
        tick;
        sweep_start = 1'b0;
        k         = 0;
        cyc       = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 2000) begin
            if (sweep_done) begin
                done_seen = 1'b1;
            end else begin
                chk("sweep_busy", sweep_busy, 1);
                rsp_ready   = ($urandom_range(0, 3) != 0);
                sweep_start = (k < 60) && ($urandom_range(0, 7) == 0);
                #1;
                chk("sweep_hold_req", req_ready, 0);
                if (ram_re) chk("sweep_ram_addr", ram_addr, k);
                if (rsp_valid && rsp_ready) begin
                    chk("sweep_data", obs, expect_rsp(k));
                    chk("sweep_addr", rsp_addr, k);
                    chk("sweep_last", rsp_last, k == RAM_SIZE - 1);
                    k++;
                end
                tick;
                cyc++;
            end
        end
        sweep_start = 1'b0;
        chk("sweep_done_seen", done_seen, 1);
        chk("sweep_count", k, RAM_SIZE);
        chk("done_busy_clear", sweep_busy, 0);
        rsp_ready = 1'b1;
        #1;
        chk("pending_req_ready", req_ready, 1);
        chk("pending_ram_re", ram_re, 1);
        chk("pending_ram_addr", ram_addr, 5);
        tick;
        req_valid = 1'b0;
        #1;
        chk("done_single_pulse", sweep_done, 0);
        tick;
        chk("pending_rsp_valid", rsp_valid, 1);
        chk("pending_rsp_data", obs, expect_rsp(5));
        chk("pending_rsp_addr", rsp_addr, 5);
        chk("pending_rsp_last", rsp_last, 0);
        tick;

        // Asynchronous reset while holding a response mid-sweep.
        sweep_start = 1'b1;
        tick;
        sweep_start = 1'b0;
        rsp_ready   = 1'b1;
        k   = 0;
        cyc = 0;
        while (k < 10 && cyc < 200) begin
            if (rsp_valid) k++;
            tick;
            cyc++;
        end
        rsp_ready = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 10) begin
            tick;
            cyc++;
        end
        chk("pre_rst_valid", rsp_valid, 1);
        chk("pre_rst_addr", rsp_addr, 10);
        chk("pre_rst_busy", sweep_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", rsp_valid, 0);
        chk("async_rst_busy", sweep_busy, 0);
        chk("async_rst_ram_re", ram_re, 0);
        chk("async_rst_req_ready", req_ready, 1);
        #1;
        rst = 1'b0;
        tick;
        sweep_start = 1'b1;
        #1;
        chk("restart_no_early_re", ram_re, 0);
        tick;
        sweep_start = 1'b0;
        #1;
        chk("restart_busy", sweep_busy, 1);
        chk("restart_ram_re", ram_re, 1);
        chk("restart_ram_addr", ram_addr, 0);
        tick;
        tick;
        chk("restart_rsp_valid", rsp_valid, 1);
        chk("restart_rsp_addr", rsp_addr, 0);
        chk("restart_rsp_data", obs, expect_rsp(0));
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
